int_receiver: RTL and testbench

//  Receives 32-bit words over the board's serial UART link (8N1, idle high).

---
 rtl/int_link_pkg.sv | 20 ++
 rtl/int_receiver_if.sv | 14 +
 rtl/int_receiver_rx_module.sv | 77 +++++++
 rtl/int_receiver.sv | 74 +++++++
 tb/tb_int_receiver.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_link_pkg.sv
// int_link_pkg: UART link constants and byte-FSM encodings shared by the receive and transmit sides
package int_link_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int TIMEOUT_BITS_DEF = 20;
    localparam int BYTES_PER_WORD   = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } byte_state_t;

endpackage

// File: rtl/int_receiver_if.sv
// int_receiver_if: word handshake bundle between the receiver (master) and its consumer (slave)
interface int_receiver_if;
    import int_link_pkg::*;

    logic [BYTES_PER_WORD*8-1:0] data;
    logic                        int_valid;
    logic                        int_ack;
    logic                        overrun;
    logic                        frame_err;

    modport master (output data, int_valid, overrun, frame_err, input int_ack);
    modport slave  (input data, int_valid, overrun, frame_err, output int_ack);

endinterface

// File: rtl/int_receiver_rx_module.sv
// rx_module: rx synchronizer plus 8N1 byte FSM producing one-cycle byte_valid / frame_err pulses
module rx_module
    import int_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1, sync2;
    byte_state_t   state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic          armed;

    assign busy = state != S_IDLE;

    // Two-flop synchronizer; resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) {sync2, sync1} <= 2'b11;
        else      {sync2, sync1} <= {sync1, rx};
    end

    // Byte FSM: qualify start bit at half-bit, sample data mid-bit, check stop bit; disarm after a bad stop
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            armed      <= 1'b0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            clk_cnt    <= clk_cnt + CW'(1);
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    if (!armed) armed <= sync2;
                    else if (!sync2) state <= S_START;
                end
                S_START: if (clk_cnt == HALF) begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    state   <= sync2 ? S_IDLE : S_DATA;
                end
                S_DATA: if (clk_cnt == LAST) begin
                    clk_cnt <= '0;
                    data    <= {sync2, data[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= S_STOP;
                end
                S_STOP: if (clk_cnt == LAST) begin
                    clk_cnt    <= '0;
                    byte_valid <= sync2;
                    frame_err  <= !sync2;
                    armed      <= sync2;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/int_receiver.sv
// int_receiver: reassembles four LSB-first UART bytes into a 32-bit word with valid/ack handshake
module int_receiver
    import int_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    int_receiver_if.master bus
);

    localparam int            TO      = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW      = $clog2(TO);
    localparam logic [TW-1:0] TO_LAST = TW'(TO - 1);
    localparam logic [1:0]    LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [7:0]    rx_byte;
    logic          byte_valid, rx_ferr, busy;
    logic [1:0]    cnt;
    logic [31:0]   shadow;
    logic [TW-1:0] idle_cnt;
    logic          pending, timeout, complete, ack;

    rx_module #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock      (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (rx_ferr),
        .busy       (busy)
    );

    assign bus.frame_err = rx_ferr;
    assign pending       = (cnt != 2'd0) && !busy;
    assign timeout       = pending && (idle_cnt == TO_LAST);
    assign complete      = byte_valid && (cnt == LAST_LANE);
    assign ack           = bus.int_ack && bus.int_valid;

    // Inter-byte idle timer: runs only while a partial word waits with the line idle; any start edge clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idle_cnt <= '0;
        else      idle_cnt <= (pending && !timeout) ? idle_cnt + TW'(1) : '0;
    end

    // Lane assembly into the shadow word; a frame error or timeout drops the partial word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            shadow <= '0;
        end else if (rx_ferr || timeout) begin
            cnt <= '0;
        end else if (byte_valid) begin
            shadow[{cnt, 3'b000} +: 8] <= rx_byte;
            cnt                        <= cnt + 2'd1;
        end
    end

    // Output word and handshake; completion wins over ack, overrun only when an unacked word is overwritten
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.data      <= '0;
            bus.int_valid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.data      <= complete ? {rx_byte, shadow[23:0]} : bus.data;
            bus.int_valid <= complete | (bus.int_valid & !ack);
            bus.overrun   <= (complete & bus.int_valid & !ack) | (bus.overrun & !ack);
        end
    end

endmodule

// File: tb/tb_int_receiver.sv
// tb_int_receiver: directed 8N1 BFM stimulus checked against a byte-level word model every quiet cycle
module tb_int_receiver;

    localparam int CPB = 8;
    localparam int TOB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   fe_cycles = 0;
    logic cmp_en = 1'b0;
    logic ok;
    int   fe0;

    logic [7:0]  part[$];
    logic [31:0] exp_data  = '0;
    logic        exp_valid = 1'b0;
    logic        exp_ovr   = 1'b0;

    int_receiver_if bus();

    int_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b);
        part.push_back(b);
        if (part.size() == 4) begin
            if (exp_valid) exp_ovr = 1'b1;
            exp_data  = {part[3], part[2], part[1], part[0]};
            exp_valid = 1'b1;
            part.delete();
        end
    endfunction

    function automatic void model_ack();
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        part.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endfunction

    // compare process: DUT against the model on every cycle the line is quiet
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("data", bus.data, exp_data);
            chk("int_valid", 32'(bus.int_valid), 32'(exp_valid));
            chk("overrun", 32'(bus.overrun), 32'(exp_ovr));
            chk("frame_err", 32'(bus.frame_err), 32'd0);
            chk("cnt", 32'(dut.cnt), 32'(part.size()));
        end
    end

    always @(negedge clk) if (bus.frame_err) fe_cycles++;

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        cmp_en = 1'b0;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        rx = 1'b1;
        if (stop) model_byte(b);
        else part.delete();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * CPB) @(negedge clk);
        if (bits >= TOB) part.delete();
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        cmp_en = 1'b1;
    endtask

    task automatic do_ack();
        cmp_en = 1'b0;
        bus.int_ack = 1'b1;
        model_ack();
        @(negedge clk);
        bus.int_ack = 1'b0;
        cmp_en = 1'b1;
    endtask

    task automatic watch_bv(input int n, output logic found);
        int seen = 0;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (dut.u_rx.byte_valid) begin
                seen++;
                if (seen == n) found = 1'b1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.int_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data", bus.data, 32'h0);
        chk("reset_valid", 32'(bus.int_valid), 32'd0);
        chk("reset_overrun", 32'(bus.overrun), 32'd0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
        rst = 1'b1;
        idle(2);
        settle();

        // 1: back-to-back bytes, valid one clk after the last byte_valid, ack clears valid only
        fork
            send_word(32'h12345678);
            begin
                watch_bv(4, ok);
                chk("t1_bv_seen", 32'(ok), 32'd1);
                chk("t1_valid_at_bv", 32'(bus.int_valid), 32'd0);
                @(negedge clk);
                chk("t1_valid_next", 32'(bus.int_valid), 32'd1);
                chk("t1_data", bus.data, 32'h12345678);
            end
        join
        settle();
        do_ack();
        settle();
        chk("t1_valid_acked", 32'(bus.int_valid), 32'd0);
        chk("t1_data_held", bus.data, 32'h12345678);

        // 2: overrun on an unacked overwrite, cleared by ack
        send_word(32'hDEADBEEF);
        settle();
        chk("t2_first", bus.data, 32'hDEADBEEF);
        send_word(32'h00000001);
        settle();
        chk("t2_data", bus.data, 32'h00000001);
        chk("t2_overrun", 32'(bus.overrun), 32'd1);
        do_ack();
        settle();
        chk("t2_overrun_clr", 32'(bus.overrun), 32'd0);
        chk("t2_valid_clr", 32'(bus.int_valid), 32'd0);

        // 3: inter-byte timeout drops a partial word
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(5);
        chk("t3_cnt_dropped", 32'(dut.cnt), 32'd0);
        chk("t3_no_valid", 32'(bus.int_valid), 32'd0);
        send_word(32'h04030201);
        settle();
        chk("t3_data", bus.data, 32'h04030201);
        do_ack();

        // 4: bad stop bit pulses frame_err for one clk and drops the partial word
        fe0 = fe_cycles;
        send_byte(8'h11);
        send_byte(8'h55, 1'b0);
        idle(1);
        chk("t4_fe_pulse", 32'(fe_cycles - fe0), 32'd1);
        chk("t4_cnt", 32'(dut.cnt), 32'd0);
        settle();
        send_word(32'h04030201);
        settle();
        chk("t4_data", bus.data, 32'h04030201);

        // 5: short glitch ignored; completion and ack in the same cycle keeps valid without overrun
        fe0 = fe_cycles;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        idle(2);
        chk("t5_glitch_fe", 32'(fe_cycles - fe0), 32'd0);
        chk("t5_glitch_cnt", 32'(dut.cnt), 32'd0);
        fork
            send_word(32'hA5A55A5A);
            begin
                watch_bv(4, ok);
                chk("t5_bv_seen", 32'(ok), 32'd1);
                bus.int_ack = 1'b1;
                model_ack();
                @(negedge clk);
                bus.int_ack = 1'b0;
                chk("t5_valid", 32'(bus.int_valid), 32'd1);
                chk("t5_overrun", 32'(bus.overrun), 32'd0);
                chk("t5_data", bus.data, 32'hA5A55A5A);
            end
        join
        settle();

        // break: a long low line gives exactly one frame_err and no re-arm until high
        cmp_en = 1'b0;
        fe0 = fe_cycles;
        rx = 1'b0;
        repeat (25 * CPB) @(negedge clk);
        rx = 1'b1;
        idle(2);
        chk("break_fe", 32'(fe_cycles - fe0), 32'd1);
        settle();

        // 6: reset mid third byte, then a clean word
        send_byte(8'h0D);
        send_byte(8'hF0);
        cmp_en = 1'b0;
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("t6_rst_data", bus.data, 32'h0);
        chk("t6_rst_valid", 32'(bus.int_valid), 32'd0);
        chk("t6_rst_overrun", 32'(bus.overrun), 32'd0);
        chk("t6_rst_fe", 32'(bus.frame_err), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);
        settle();
        send_word(32'hCAFEF00D);
        settle();
        chk("t6_data", bus.data, 32'hCAFEF00D);
        chk("t6_valid", 32'(bus.int_valid), 32'd1);
        repeat (4) @(negedge clk);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
